flags_wb_reg: RTL and testbench
===============================

FLAGS_WB_REG -- requirements
Module: flags_wb_reg

Interface
REQ-001 The block SHALL have parameter RESET_VAL, default 6'b000000, meaning the value loaded into eflags on reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port ex_v  input  1  the execute stage presents a flag result this cycle.
REQ-005 The block SHALL have port ex_flags  input  6  the flag result, bit index CF=0, PF=1, AF=2, ZF=3, SF=4, OF=5.
REQ-006 The block SHALL have port ex_mask  input  6  per-flag update enable, same bit order as ex_flags.
REQ-007 The block SHALL have port ex_ready  output  1  the block accepts ex_v this cycle.
REQ-008 The block SHALL have port wb_stall  input  1  writeback cannot commit this cycle.
REQ-009 The block SHALL have port flush  input  1  squash the pending entry and any same-cycle ex_v.
REQ-010 The block SHALL have port ld_v  input  1  direct architectural load of all six flags (popf-type).
REQ-011 The block SHALL have port ld_flags  input  6  the load value.
REQ-012 The block SHALL have port eflags  output  6  the committed architectural flags.
REQ-013 The block SHALL have port fwd_flags  output  6  committed flags merged with the pending entry, for bypass to the next instruction.
REQ-014 The block SHALL have port pend  output  1  a one-entry latch holds an uncommitted result.
REQ-015 The block SHALL have port commit_v  output  1  a registered one-cycle pulse after each commit.
REQ-016 The block SHALL have port commit_cnt  output  8  the count of commits, wrapping at 255 to 0.

Function
REQ-017 The block SHALL drive ex_ready = !pend | !wb_stall, combinationally.
REQ-018 On an edge with ex_v & ex_ready & !flush, the block SHALL capture ex_flags and ex_mask into the latch and set pend=1.
REQ-019 On an edge with pend & !wb_stall & !flush & !ld_v, the block SHALL commit: eflags <= (eflags & ~mask_q) | (flags_q & mask_q).
REQ-020 On a commit without a same-edge accept, the block SHALL clear pend; a commit and an accept on the same edge SHALL leave pend=1 holding the new entry.
REQ-021 With pend=1 and wb_stall=1, the block SHALL hold the latch, eflags and pend unchanged and ignore ex_v.
REQ-022 On an edge with flush=1, the block SHALL clear pend, drop ex_v, and leave eflags unchanged, unless ld_v=1, in which case REQ-023 applies.
REQ-023 On an edge with ld_v=1, the block SHALL set eflags <= ld_flags, clear pend (discarding any pending entry), and SHALL NOT count a commit; ld_v has highest priority.
REQ-024 The block SHALL drive fwd_flags = pend ? (eflags & ~mask_q) | (flags_q & mask_q) : eflags, combinationally.
REQ-025 The block SHALL assert commit_v for exactly the one cycle following each commit edge.
REQ-026 The block SHALL increment commit_cnt by 1 on each commit edge, modulo 256.
REQ-027 Latency SHALL be as follows: an entry accepted at edge N commits at edge N+1 if not stalled, with eflags updated and commit_v=1 during cycle N+1 to N+2.
REQ-028 With a zero ex_mask, the entry SHALL still occupy the latch, commit, pulse commit_v and count, but leave eflags unchanged.

Reset
REQ-029 While rst=1, the block SHALL immediately, independent of clk, force eflags=RESET_VAL, pend=0, commit_v=0, commit_cnt=0, and latch flags/mask=0.
REQ-030 Reset asserted mid-operation SHALL discard the pending entry with no commit; the first edge after deassertion SHALL behave as an empty latch.

Verification
REQ-031 The bench SHALL cover: reset, then ex_v=1 with ex_flags=6'b011010 and ex_mask=6'b111111 -> the next cycle shows pend=1 and fwd_flags=6'b011010; the cycle after shows eflags=6'b011010, commit_v=1, commit_cnt=1.
REQ-032 The bench SHALL cover: eflags=6'b111111, then an entry with flags=6'b000000 and mask=6'b000101 -> after commit, eflags=6'b111010.
REQ-033 The bench SHALL cover: pend=1 with wb_stall=1 for 3 cycles while ex_v=1 -> ex_ready=0 and eflags unchanged; stall drops -> commit and accept on the same edge, pend stays 1 with the new entry.
REQ-034 The bench SHALL cover: pend=1 with flush=1 and ex_v=1 -> pend=0, eflags unchanged, commit_v=0.
REQ-035 The bench SHALL cover: pend=1 with ld_v=1 and ld_flags=6'b100001 -> eflags=6'b100001, pend=0, commit_cnt unchanged.
REQ-036 The bench SHALL cover: 256 back-to-back commits -> commit_cnt wraps to 0; rst asserted mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/flags_wb_reg.sv
// Writeback-stage flags register: a one-entry latch holds a masked flag result
// until writeback commits it into the architectural eflags.
module flags_wb_reg #(
    parameter logic [5:0] RESET_VAL = 6'b000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_v,
    input  logic [5:0] ex_flags,
    input  logic [5:0] ex_mask,
    output logic       ex_ready,
    input  logic       wb_stall,
    input  logic       flush,
    input  logic       ld_v,
    input  logic [5:0] ld_flags,
    output logic [5:0] eflags,
    output logic [5:0] fwd_flags,
    output logic       pend,
    output logic       commit_v,
    output logic [7:0] commit_cnt
);

    logic       r_pend;
    logic [5:0] r_flags;
    logic [5:0] r_mask;
    logic [5:0] r_eflags;
    logic       r_commit_v;
    logic [7:0] r_commit_cnt;

    logic       w_accept;
    logic       w_commit;
    logic [5:0] w_merged;

    // The latch frees up on the same edge it commits, so a stalled-then-released
    // entry can be replaced without a bubble.
    assign ex_ready = !r_pend || !wb_stall;
    assign w_accept = ex_v && ex_ready && !flush && !ld_v;
    assign w_commit = r_pend && !wb_stall && !flush && !ld_v;
    assign w_merged = (r_eflags & ~r_mask) | (r_flags & r_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= 1'b0;
            r_flags      <= 6'b000000;
            r_mask       <= 6'b000000;
            r_eflags     <= RESET_VAL;
            r_commit_v   <= 1'b0;
            r_commit_cnt <= 8'd0;
        end else begin
            r_commit_v <= w_commit;
            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + 8'd1;
            end
            // A direct load overrides everything and discards the pending entry.
            if (ld_v) begin
                r_eflags <= ld_flags;
                r_pend   <= 1'b0;
            end else if (flush) begin
                r_pend <= 1'b0;
            end else begin
                if (w_commit) begin
                    r_eflags <= w_merged;
                end
                if (w_accept) begin
                    r_flags <= ex_flags;
                    r_mask  <= ex_mask;
                    r_pend  <= 1'b1;
                end else if (w_commit) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

    assign eflags     = r_eflags;
    assign fwd_flags  = r_pend ? w_merged : r_eflags;
    assign pend       = r_pend;
    assign commit_v   = r_commit_v;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_flags_wb_reg.sv
// Self-checking bench for flags_wb_reg: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_flags_wb_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ex_v = 1'b0;
    logic [5:0] ex_flags = 6'b0;
    logic [5:0] ex_mask = 6'b0;
    logic       ex_ready;
    logic       wb_stall = 1'b0;
    logic       flush = 1'b0;
    logic       ld_v = 1'b0;
    logic [5:0] ld_flags = 6'b0;
    logic [5:0] eflags;
    logic [5:0] fwd_flags;
    logic       pend;
    logic       commit_v;
    logic [7:0] commit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    flags_wb_reg dut (
        .clk        (clk),
        .rst        (rst),
        .ex_v       (ex_v),
        .ex_flags   (ex_flags),
        .ex_mask    (ex_mask),
        .ex_ready   (ex_ready),
        .wb_stall   (wb_stall),
        .flush      (flush),
        .ld_v       (ld_v),
        .ld_flags   (ld_flags),
        .eflags     (eflags),
        .fwd_flags  (fwd_flags),
        .pend       (pend),
        .commit_v   (commit_v),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending entries in a queue, flags applied bit by bit.
    typedef struct packed {
        logic [5:0] f;
        logic [5:0] m;
    } ent_t;

    ent_t       m_q[$];
    logic [5:0] m_ef;
    int         m_cnt;
    bit         m_cv;

    task automatic model_reset();
        m_q.delete();
        m_ef  = 6'b000000;
        m_cnt = 0;
        m_cv  = 1'b0;
    endtask

    function automatic logic [5:0] model_fwd();
        logic [5:0] r;
        r = m_ef;
        if (m_q.size() != 0) begin
            for (int i = 0; i < 6; i++) begin
                if (m_q[0].m[i]) r[i] = m_q[0].f[i];
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        bit   can_take;
        bit   do_commit;
        bit   do_take;
        ent_t e;
        can_take  = (m_q.size() == 0) || !wb_stall;
        do_commit = (m_q.size() != 0) && !wb_stall && !flush && !ld_v;
        do_take   = ex_v && can_take && !flush && !ld_v;
        m_cv      = do_commit;
        if (ld_v) begin
            m_ef = ld_flags;
            m_q.delete();
        end else if (flush) begin
            m_q.delete();
        end else begin
            if (do_commit) begin
                e = m_q.pop_front();
                for (int i = 0; i < 6; i++) begin
                    if (e.m[i]) m_ef[i] = e.f[i];
                end
                m_cnt = (m_cnt + 1) % 256;
            end
            if (do_take) begin
                e.f = ex_flags;
                e.m = ex_mask;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_v     = 1'b0;
        ex_flags = 6'b0;
        ex_mask  = 6'b0;
        wb_stall = 1'b0;
        flush    = 1'b0;
        ld_v     = 1'b0;
        ld_flags = 6'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (eflags !== 6'b000000) begin
            n_errors++; $display("FAIL reset_eflags: got %b expected %b", eflags, 6'b0);
        end
        n_checks++;
        if (pend !== 1'b0 || commit_v !== 1'b0 || commit_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state: got pend=%b cv=%b cnt=%0d expected 0 0 0",
                     pend, commit_v, commit_cnt);
        end
        n_checks++;
        if (ex_ready !== 1'b1 || fwd_flags !== 6'b000000) begin
            n_errors++;
            $display("FAIL reset_ready_fwd: got rdy=%b fwd=%b expected 1 000000",
                     ex_ready, fwd_flags);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        ex_v = 1'b1; ex_flags = 6'b011010; ex_mask = 6'b111111;
        tick();
        idle_inputs();
        n_checks++;
        if (pend !== 1'b1 || fwd_flags !== 6'b011010 || eflags !== 6'b000000) begin
            n_errors++;
            $display("FAIL basic_accept: got pend=%b fwd=%b ef=%b expected 1 011010 000000",
                     pend, fwd_flags, eflags);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b011010 || commit_v !== 1'b1 || commit_cnt !== 8'd1 || pend !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_commit: got ef=%b cv=%b cnt=%0d pend=%b expected 011010 1 1 0",
                     eflags, commit_v, commit_cnt, pend);
        end
        tick();
        n_checks++;
        if (commit_v !== 1'b0) begin
            n_errors++; $display("FAIL basic_pulse: got cv=%b expected 0", commit_v);
        end
    endtask

    task automatic test_mask();
        ld_v = 1'b1; ld_flags = 6'b111111;
        tick();
        idle_inputs();
        ex_v = 1'b1; ex_flags = 6'b000000; ex_mask = 6'b000101;
        tick();
        idle_inputs();
        n_checks++;
        if (fwd_flags !== 6'b111010 || eflags !== 6'b111111) begin
            n_errors++;
            $display("FAIL mask_fwd: got fwd=%b ef=%b expected 111010 111111", fwd_flags, eflags);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b111010 || commit_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL mask_commit: got ef=%b cnt=%0d expected 111010 2", eflags, commit_cnt);
        end
        // Zero mask still occupies the latch and counts as a commit.
        ex_v = 1'b1; ex_flags = 6'b000000; ex_mask = 6'b000000;
        tick();
        idle_inputs();
        n_checks++;
        if (pend !== 1'b1) begin
            n_errors++; $display("FAIL zero_mask_pend: got %b expected 1", pend);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b111010 || commit_v !== 1'b1 || commit_cnt !== 8'd3) begin
            n_errors++;
            $display("FAIL zero_mask_commit: got ef=%b cv=%b cnt=%0d expected 111010 1 3",
                     eflags, commit_v, commit_cnt);
        end
    endtask

    task automatic test_stall();
        ex_v = 1'b1; ex_flags = 6'b000011; ex_mask = 6'b111111;
        tick();
        wb_stall = 1'b1; ex_flags = 6'b110000;
        #1;
        n_checks++;
        if (ex_ready !== 1'b0) begin
            n_errors++; $display("FAIL stall_ready: got %b expected 0", ex_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (pend !== 1'b1 || eflags !== 6'b111010 || fwd_flags !== 6'b000011 ||
                commit_v !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got pend=%b ef=%b fwd=%b cv=%b expected 1 111010 000011 0",
                         i, pend, eflags, fwd_flags, commit_v);
            end
        end
        wb_stall = 1'b0;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_errors++; $display("FAIL stall_release_ready: got %b expected 1", ex_ready);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (eflags !== 6'b000011 || pend !== 1'b1 || fwd_flags !== 6'b110000 ||
            commit_v !== 1'b1 || commit_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL stall_swap: got ef=%b pend=%b fwd=%b cv=%b cnt=%0d expected 000011 1 110000 1 4",
                     eflags, pend, fwd_flags, commit_v, commit_cnt);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b110000 || pend !== 1'b0 || commit_cnt !== 8'd5) begin
            n_errors++;
            $display("FAIL stall_drain: got ef=%b pend=%b cnt=%0d expected 110000 0 5",
                     eflags, pend, commit_cnt);
        end
    endtask

    task automatic test_flush();
        ex_v = 1'b1; ex_flags = 6'b101010; ex_mask = 6'b111111;
        tick();
        flush = 1'b1; ex_flags = 6'b010101;
        tick();
        idle_inputs();
        n_checks++;
        if (pend !== 1'b0 || eflags !== 6'b110000 || commit_v !== 1'b0 || commit_cnt !== 8'd5) begin
            n_errors++;
            $display("FAIL flush: got pend=%b ef=%b cv=%b cnt=%0d expected 0 110000 0 5",
                     pend, eflags, commit_v, commit_cnt);
        end
        tick();
        n_checks++;
        if (pend !== 1'b0 || eflags !== 6'b110000 || commit_v !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_after: got pend=%b ef=%b cv=%b expected 0 110000 0",
                     pend, eflags, commit_v);
        end
    endtask

    task automatic test_load();
        ex_v = 1'b1; ex_flags = 6'b001100; ex_mask = 6'b111111;
        tick();
        idle_inputs();
        ld_v = 1'b1; ld_flags = 6'b100001;
        tick();
        idle_inputs();
        n_checks++;
        if (eflags !== 6'b100001 || pend !== 1'b0 || commit_cnt !== 8'd5 || commit_v !== 1'b0) begin
            n_errors++;
            $display("FAIL load: got ef=%b pend=%b cnt=%0d cv=%b expected 100001 0 5 0",
                     eflags, pend, commit_cnt, commit_v);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b100001 || commit_v !== 1'b0) begin
            n_errors++;
            $display("FAIL load_after: got ef=%b cv=%b expected 100001 0", eflags, commit_v);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ex_v     = ($urandom_range(0, 9) < 7);
            ex_flags = 6'($urandom);
            ex_mask  = 6'($urandom);
            wb_stall = ($urandom_range(0, 9) < 3);
            flush    = ($urandom_range(0, 9) == 0);
            ld_v     = ($urandom_range(0, 24) < 2);
            ld_flags = 6'($urandom);
            #1;
            n_checks++;
            if (ex_ready !== (m_q.size() == 0 || !wb_stall)) begin
                n_errors++;
                $display("FAIL rand_ready c%0d: got %b expected %b", c, ex_ready,
                         (m_q.size() == 0 || !wb_stall));
            end
            n_checks++;
            if (fwd_flags !== model_fwd()) begin
                n_errors++;
                $display("FAIL rand_fwd c%0d: got %b expected %b", c, fwd_flags, model_fwd());
            end
            tick();
            n_checks++;
            if (eflags !== m_ef) begin
                n_errors++; $display("FAIL rand_eflags c%0d: got %b expected %b", c, eflags, m_ef);
            end
            n_checks++;
            if (pend !== (m_q.size() != 0)) begin
                n_errors++;
                $display("FAIL rand_pend c%0d: got %b expected %b", c, pend, (m_q.size() != 0));
            end
            n_checks++;
            if (commit_v !== m_cv || commit_cnt !== 8'(m_cnt)) begin
                n_errors++;
                $display("FAIL rand_commit c%0d: got cv=%b cnt=%0d expected cv=%b cnt=%0d",
                         c, commit_v, commit_cnt, m_cv, m_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ex_v = 1'b1; ex_mask = 6'b111111;
        for (int k = 1; k <= 256; k++) begin
            ex_flags = 6'($urandom);
            tick();
        end
        n_checks++;
        if (commit_cnt !== 8'd255 || pend !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_255: got cnt=%0d pend=%b expected 255 1", commit_cnt, pend);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (commit_cnt !== 8'd0 || commit_v !== 1'b1 || eflags !== m_ef) begin
            n_errors++;
            $display("FAIL b2b_wrap: got cnt=%0d cv=%b ef=%b expected 0 1 %b",
                     commit_cnt, commit_v, eflags, m_ef);
        end
        // Mid-stream asynchronous reset with an entry pending.
        ex_v = 1'b1; ex_flags = 6'b110011; ex_mask = 6'b111111;
        for (int k = 0; k < 5; k++) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (eflags !== 6'b000000 || pend !== 1'b0 || commit_v !== 1'b0 ||
            commit_cnt !== 8'd0 || fwd_flags !== 6'b000000) begin
            n_errors++;
            $display("FAIL async_reset: got ef=%b pend=%b cv=%b cnt=%0d fwd=%b expected all 0",
                     eflags, pend, commit_v, commit_cnt, fwd_flags);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        ex_flags = 6'b000111; wb_stall = 1'b1;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_ready: got %b expected 1", ex_ready);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (pend !== 1'b1 || commit_cnt !== 8'd0 || commit_v !== 1'b0 || eflags !== 6'b000000) begin
            n_errors++;
            $display("FAIL post_reset_accept: got pend=%b cnt=%0d cv=%b ef=%b expected 1 0 0 000000",
                     pend, commit_cnt, commit_v, eflags);
        end
        tick();
        n_checks++;
        if (eflags !== 6'b000111 || commit_cnt !== 8'd1 || pend !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_commit: got ef=%b cnt=%0d pend=%b expected 000111 1 0",
                     eflags, commit_cnt, pend);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_mask();
        test_stall();
        test_flush();
        test_load();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
